// File: rtl/tri_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter_if
//   Bundles the request/grant signals exchanged between the requesting units
//   and the tri-state bus arbiter.
//
//   Signals
//     req    N_REQ  level request, one bit per requester
//     gnt    N_REQ  one-hot registered grant
//     E      N_REQ  three-state buffer enables (always equal to gnt)
//     owner  OW     index of the current or most recent bus owner
//     busy   1      some requester currently owns the bus
//
//   Modports
//     master  requester side: drives req, observes the arbiter outputs
//     slave   arbiter side: observes req, drives gnt/E/owner/busy
// -----------------------------------------------------------------------------
interface tri_bus_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] E;
    logic [OW-1:0]    owner;
    logic             busy;

    modport master (
        output req,
        input  gnt,
        input  E,
        input  owner,
        input  busy
    );

    modport slave (
        input  req,
        output gnt,
        output E,
        output owner,
        output busy
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
//   Round-robin arbiter sharing one tri-state data bus between N_REQ
//   three-state buffer drivers. The grant doubles as the buffer enable E.
//   Every change of bus owner passes through at least TURN_CYC cycles with all
//   enables off, so two drivers can never fight on the bus. While somebody
//   else is waiting, an owner keeps the bus for at most HOLD_MAX cycles; a
//   lone requester keeps it for as long as it asks.
//
//   Parameters
//     N_REQ     number of requesters / buffer drivers (>= 2)
//     HOLD_MAX  max consecutive grant cycles while another request pends
//     TURN_CYC  all-enables-off cycles between two owners (>= 1)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset; drops every enable at once
//     bus    slave side of tri_bus_arbiter_if (req in; gnt, E, owner, busy out)
// -----------------------------------------------------------------------------
module tri_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    tri_bus_arbiter_if.slave   bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int CW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t            state_r;
    logic [N_REQ-1:0]  gnt_r;
    logic [OW-1:0]     owner_r;
    logic              busy_r;
    logic [OW-1:0]     ptr_r;
    logic [TW-1:0]     tenure_r;
    logic [CW-1:0]     turn_cnt_r;

    logic [OW-1:0]     pick_s;
    logic              others_s;
    logic              release_s;
    logic [OW-1:0]     ptr_next_s;

    // Round-robin search: first set bit of r starting at p and wrapping.
    // Walking the offsets from farthest to nearest lets the nearest hit win
    // without needing an early exit from the loop.
    function automatic logic [OW-1:0] rr_pick(
        input logic [N_REQ-1:0] r,
        input logic [OW-1:0]    p
    );
        logic [OW-1:0] win;
        logic [OW:0]   sum;
        win = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, p} + (OW + 1)'(k);
            if (sum >= (OW + 1)'(N_REQ)) begin
                sum = sum - (OW + 1)'(N_REQ);
            end else begin
                sum = sum;
            end
            if (r[sum[OW-1:0]]) begin
                win = sum[OW-1:0];
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] to_onehot(input logic [OW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = {N_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner selection, release decision and next search start.
    always_comb begin
        pick_s   = rr_pick(bus.req, ptr_r);
        others_s = |(bus.req & ~gnt_r);

        // Release when the owner lets go, or when its tenure is used up and
        // someone else is waiting. A lone owner is never forced off.
        if (bus.req[owner_r] == 1'b0) begin
            release_s = 1'b1;
        end else if ((tenure_r == TW'(HOLD_MAX)) && others_s) begin
            release_s = 1'b1;
        end else begin
            release_s = 1'b0;
        end

        if (owner_r == OW'(N_REQ - 1)) begin
            ptr_next_s = {OW{1'b0}};
        end else begin
            ptr_next_s = owner_r + OW'(1);
        end
    end

    // Arbitration state machine; every output is a register so the buffer
    // enables are glitch-free and the reset path clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {N_REQ{1'b0}};
            owner_r    <= {OW{1'b0}};
            busy_r     <= 1'b0;
            ptr_r      <= {OW{1'b0}};
            tenure_r   <= {TW{1'b0}};
            turn_cnt_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_r  <= ST_GRANT;
                        gnt_r    <= to_onehot(pick_s);
                        owner_r  <= pick_s;
                        busy_r   <= 1'b1;
                        tenure_r <= TW'(1);
                    end else begin
                        state_r  <= ST_IDLE;
                        gnt_r    <= {N_REQ{1'b0}};
                        busy_r   <= 1'b0;
                    end
                end

                ST_GRANT: begin
                    if (release_s) begin
                        // Owner is kept so the bus reports who drove last.
                        state_r    <= ST_TURN;
                        gnt_r      <= {N_REQ{1'b0}};
                        busy_r     <= 1'b0;
                        ptr_r      <= ptr_next_s;
                        turn_cnt_r <= CW'(1);
                    end else if (tenure_r != TW'(HOLD_MAX)) begin
                        tenure_r <= tenure_r + TW'(1);
                    end else begin
                        tenure_r <= tenure_r;
                    end
                end

                ST_TURN: begin
                    if (turn_cnt_r >= CW'(TURN_CYC)) begin
                        // Requests are only looked at when the gap closes;
                        // the previous owner wins only if nobody else asks.
                        if (|bus.req) begin
                            state_r  <= ST_GRANT;
                            gnt_r    <= to_onehot(pick_s);
                            owner_r  <= pick_s;
                            busy_r   <= 1'b1;
                            tenure_r <= TW'(1);
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        turn_cnt_r <= turn_cnt_r + CW'(1);
                    end
                end

                default: begin
                    state_r    <= ST_IDLE;
                    gnt_r      <= {N_REQ{1'b0}};
                    busy_r     <= 1'b0;
                    turn_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.E     = gnt_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tri_bus_arbiter
//   Directed and random stimulus for tri_bus_arbiter (N_REQ=4, HOLD_MAX=4,
//   TURN_CYC=1). A behavioural model tracks who holds the bus, how long it
//   has held it and how many gap cycles remain; a compare process checks the
//   DUT against it every cycle together with the bus invariants, and the
//   directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_tri_bus_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int TURN = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   check_en = 1'b0;

    always #5 clk = ~clk;

    tri_bus_arbiter_if #(.N_REQ(N)) bus_if ();

    tri_bus_arbiter #(
        .N_REQ   (N),
        .HOLD_MAX(HOLD),
        .TURN_CYC(TURN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First requester at or after start, wrapping around.
    function automatic int pick(input logic [N-1:0] r, input int start);
        int w;
        bit found;
        w = -1;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && r[(start + k) % N]) begin
                w = (start + k) % N;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Model state: holder (-1 = nobody), cycles held, gap cycles left,
    // where the next search starts, and the last reported owner.
    int           m_holder = -1;
    int           m_held   = 0;
    int           m_gap    = 0;
    int           m_start  = 0;
    int           m_owner  = 0;
    logic [N-1:0] m_req_edge = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_holder = -1; m_held = 0; m_gap = 0; m_start = 0; m_owner = 0;
                m_req_edge = '0;
            end else begin
                m_req_edge = bus_if.req;
                if (m_holder >= 0) begin
                    if (!bus_if.req[m_holder] ||
                        (m_held >= HOLD && (bus_if.req & ~onehot(m_holder)) != '0)) begin
                        m_start  = (m_holder + 1) % N;
                        m_holder = -1;
                        m_gap    = TURN;
                    end else if (m_held < HOLD) begin
                        m_held++;
                    end
                end else begin
                    if (m_gap > 0) m_gap--;
                    if (m_gap == 0 && bus_if.req != '0) begin
                        m_holder = pick(bus_if.req, m_start);
                        m_owner  = m_holder;
                        m_held   = 1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model plus the bus invariants.
    logic [N-1:0] last_gnt = '0;
    int           zero_run = TURN;
    initial begin
        logic [N-1:0] exp_gnt;
        forever begin
            @(negedge clk);
            if (check_en) begin
                exp_gnt = (m_holder >= 0) ? onehot(m_holder) : '0;
                check("model_gnt",   32'(bus_if.gnt),   32'(exp_gnt));
                check("model_E",     32'(bus_if.E),     32'(exp_gnt));
                check("model_owner", 32'(bus_if.owner), 32'(m_owner));
                check("model_busy",  32'(bus_if.busy),  32'(m_holder >= 0));
                check("inv_onehot",  32'($countones(bus_if.gnt) <= 1), 32'd1);
                if (!rst_n) begin
                    last_gnt = '0;
                    zero_run = TURN;
                end else if (bus_if.gnt != '0) begin
                    check("inv_grant_has_req", 32'((bus_if.gnt & m_req_edge) == bus_if.gnt), 32'd1);
                    if (last_gnt != '0 && bus_if.gnt != last_gnt)
                        check("inv_turn_gap", 32'(zero_run >= TURN), 32'd1);
                    last_gnt = bus_if.gnt;
                    zero_run = 0;
                end else begin
                    zero_run++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst_n = 1'b0;
        bus_if.req = r;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] exp_v;
        bus_if.req = '0;
        #1;
        rst_n = 1'b0;
        check_en = 1'b1;
        tick();
        tick();
        check("reset_gnt",   32'(bus_if.gnt),   32'd0);
        check("reset_E",     32'(bus_if.E),     32'd0);
        check("reset_owner", 32'(bus_if.owner), 32'd0);
        check("reset_busy",  32'(bus_if.busy),  32'd0);
        rst_n = 1'b1;

        // Single requester: one-cycle latency, hold, release, idle.
        bus_if.req = 4'b0010;
        tick();
        check("t1_gnt",   32'(bus_if.gnt),   32'h2);
        check("t1_E",     32'(bus_if.E),     32'h2);
        check("t1_owner", 32'(bus_if.owner), 32'd1);
        check("t1_busy",  32'(bus_if.busy),  32'd1);
        repeat (3) begin
            tick();
            check("t1_hold", 32'(bus_if.gnt), 32'h2);
        end
        bus_if.req = 4'b0000;
        tick();
        check("t1_drop_gnt",   32'(bus_if.gnt),   32'h0);
        check("t1_drop_busy",  32'(bus_if.busy),  32'd0);
        check("t1_drop_owner", 32'(bus_if.owner), 32'd1);
        tick();
        check("t1_idle_gnt", 32'(bus_if.gnt), 32'h0);

        // All requesting: 4 grant cycles each, one gap, rotating from bit 0.
        do_reset(4'b1111);
        for (int c = 1; c <= 21; c++) begin
            tick();
            if ((c - 1) % 5 == 4) exp_v = 4'b0000;
            else                  exp_v = onehot(((c - 1) / 5) % 4);
            check("t2_rotate", 32'(bus_if.gnt), 32'(exp_v));
        end

        // Owner 3 hits its tenure cap with req=1001; search wraps to bit 0.
        do_reset(4'b1000);
        tick();
        check("t3_grant3", 32'(bus_if.gnt), 32'h8);
        bus_if.req = 4'b1001;
        repeat (3) begin
            tick();
            check("t3_hold3", 32'(bus_if.gnt), 32'h8);
        end
        tick();
        check("t3_gap",       32'(bus_if.gnt),   32'h0);
        check("t3_gap_owner", 32'(bus_if.owner), 32'd3);
        tick();
        check("t3_wrap_gnt",   32'(bus_if.gnt),   32'h1);
        check("t3_wrap_owner", 32'(bus_if.owner), 32'd0);

        // Lone requester keeps the bus with no forced gaps.
        do_reset(4'b0100);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t4_lone", 32'(bus_if.gnt), 32'h4);
        end

        // Move the search start to 2, then reset mid-cycle during a grant.
        do_reset(4'b0010);
        tick();
        bus_if.req = 4'b0000;
        tick();
        bus_if.req = 4'b0010;
        tick();
        check("t5_pre_gnt", 32'(bus_if.gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt",  32'(bus_if.gnt),  32'h0);
        check("t5_async_E",    32'(bus_if.E),    32'h0);
        check("t5_async_busy", 32'(bus_if.busy), 32'd0);
        @(posedge clk);
        #1;
        bus_if.req = 4'b1010;
        rst_n = 1'b1;
        tick();
        check("t5_regrant_gnt",   32'(bus_if.gnt),   32'h2);
        check("t5_regrant_owner", 32'(bus_if.owner), 32'd1);

        // Random traffic; model and invariants checked every cycle.
        do_reset(4'b0000);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom_range(0, 15));
            tick();
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
